// File: rtl/img_seq_ctrl.sv
`default_nettype none
// ============================================================================
// img_seq_ctrl : per-image sequencer with spike counting and argmax readout.
// Optional RUN watchdog with sticky wdog_err is enabled by IMG_SEQ_WDOG_EN.
// Revision: 1.0
// ============================================================================
module img_seq_ctrl #(
  parameter int N    = 8,
  parameter int CW   = 8,
  parameter int WDOG = 65535,
  localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          img_valid,
  output logic          img_ready,
  output logic          start_core_img,
  input  logic          TU_incre,
  input  logic [N-1:0]  ops,
  input  logic          done_core_img,
  output logic          busy,
  output logic          result_valid,
  input  logic          result_ready,
  output logic [IW-1:0] result_idx,
  output logic [CW-1:0] result_cnt,
  output logic          no_spike
`ifdef IMG_SEQ_WDOG_EN
  ,
  output logic          wdog_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_RUN    = 3'd2,
    S_ARGMAX = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t                 state;
  logic [N-1:0][CW-1:0]   cnt;
  logic [IW-1:0]          scan_idx;
  logic [CW-1:0]          run_max;
  logic [IW-1:0]          run_idx;
  logic [CW-1:0]          cur_cnt;
  logic                   take;
  logic [CW-1:0]          max_nxt;
  logic [IW-1:0]          idx_nxt;
  logic                   scan_last;
  logic                   accept;
  logic                   wdog_fire;

  assign accept    = (state == S_IDLE) && img_valid;
  assign scan_last = (scan_idx == IW'(N - 1));

  // Strict compare keeps the earliest index on ties.
  assign cur_cnt = cnt[scan_idx];
  assign take    = cur_cnt > run_max;
  assign max_nxt = take ? cur_cnt  : run_max;
  assign idx_nxt = take ? scan_idx : run_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if ((state == S_RUN) && TU_incre) begin
      for (int i = 0; i < N; i++) begin
        if (ops[i] && (cnt[i] != {CW{1'b1}})) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      img_ready      <= 1'b1;
      start_core_img <= 1'b0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      result_idx     <= '0;
      result_cnt     <= '0;
      no_spike       <= 1'b0;
      scan_idx       <= '0;
      run_max        <= '0;
      run_idx        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (img_valid) begin
            state          <= S_START;
            img_ready      <= 1'b0;
            start_core_img <= 1'b1;
            busy           <= 1'b1;
          end
        end
        S_START: begin
          state          <= S_RUN;
          start_core_img <= 1'b0;
        end
        S_RUN: begin
          if (done_core_img || wdog_fire) begin
            state    <= S_ARGMAX;
            scan_idx <= '0;
            run_max  <= '0;
            run_idx  <= '0;
          end
        end
        S_ARGMAX: begin
          run_max  <= max_nxt;
          run_idx  <= idx_nxt;
          scan_idx <= scan_idx + IW'(1);
          if (scan_last) begin
            state        <= S_RESULT;
            result_valid <= 1'b1;
            result_idx   <= idx_nxt;
            result_cnt   <= max_nxt;
            no_spike     <= (max_nxt == '0);
          end
        end
        S_RESULT: begin
          if (result_ready) begin
            state        <= S_IDLE;
            result_valid <= 1'b0;
            img_ready    <= 1'b1;
            busy         <= 1'b0;
          end
        end
        default: begin
          state          <= S_IDLE;
          img_ready      <= 1'b1;
          start_core_img <= 1'b0;
          busy           <= 1'b0;
          result_valid   <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMG_SEQ_WDOG_EN
  localparam int DW = $clog2(WDOG + 1);

  logic [DW-1:0] wdog_cnt;

  // Fires on the WDOG-th RUN cycle so ARGMAX starts right after it.
  assign wdog_fire = (state == S_RUN) && !done_core_img && (wdog_cnt == DW'(WDOG - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state == S_START) begin
        wdog_cnt <= '0;
      end else if (state == S_RUN) begin
        wdog_cnt <= wdog_cnt + DW'(1);
      end
      if (accept) begin
        wdog_err <= 1'b0;
      end else if (wdog_fire) begin
        wdog_err <= 1'b1;
      end
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG;
  assign wdog_fire   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_img_seq_ctrl.sv
`timescale 1ns/1ps
// Bench for img_seq_ctrl: timeline-driven expectations plus a spike-count/argmax model.
module tb_img_seq_ctrl;
  localparam int N    = 8;
  localparam int CW   = 8;
  localparam int WDOG = 100;
  localparam int IW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          img_valid = 1'b0;
  logic          TU_incre = 1'b0;
  logic [N-1:0]  ops = '0;
  logic          done_core_img = 1'b0;
  logic          result_ready = 1'b0;
  logic          img_ready, start_core_img, busy, result_valid, no_spike;
  logic [IW-1:0] result_idx;
  logic [CW-1:0] result_cnt;
`ifdef IMG_SEQ_WDOG_EN
  logic          wdog_err;
`endif

  img_seq_ctrl #(.N(N), .CW(CW), .WDOG(WDOG)) dut (
    .clk(clk), .rst(rst), .img_valid(img_valid), .img_ready(img_ready),
    .start_core_img(start_core_img), .TU_incre(TU_incre), .ops(ops),
    .done_core_img(done_core_img), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .result_idx(result_idx), .result_cnt(result_cnt),
    .no_spike(no_spike)
`ifdef IMG_SEQ_WDOG_EN
    , .wdog_err(wdog_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         tu;
    logic [N-1:0] ops;
  } ent_t;

  ent_t run_q[$];
  int   mcnt[N];
  int   n_chk = 0;
  int   n_fail = 0;

  bit            chk_en = 1'b0;
  logic          exp_ready, exp_start, exp_busy, exp_rv, exp_ns, exp_wdog;
  logic [IW-1:0] exp_idx;
  logic [CW-1:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("img_ready", 32'(img_ready), 32'(exp_ready));
      chk("start_core_img", 32'(start_core_img), 32'(exp_start));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("result_valid", 32'(result_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("result_idx", 32'(result_idx), 32'(exp_idx));
        chk("result_cnt", 32'(result_cnt), 32'(exp_cnt));
        chk("no_spike", 32'(no_spike), 32'(exp_ns));
      end
`ifdef IMG_SEQ_WDOG_EN
      chk("wdog_err", 32'(wdog_err), 32'(exp_wdog));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_set(input logic r, input logic s, input logic b, input logic v);
    exp_ready = r; exp_start = s; exp_busy = b; exp_rv = v;
  endtask

  task automatic noise_in(input bit en);
    TU_incre      = en ? 1'($urandom_range(0, 1)) : 1'b0;
    ops           = en ? N'($urandom) : '0;
    done_core_img = en ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic push(input logic tu, input logic [N-1:0] o);
    ent_t e;
    e.tu = tu;
    e.ops = o;
    run_q.push_back(e);
  endtask

  // One image: IDLE handshake, START, RUN from run_q, N-cycle scan, RESULT held 'hold' cycles.
  task automatic do_image(input int hold, input bit noise, input bit wdog_case,
                          input bit lit_en, input int lit_idx, input int lit_cnt, input int lit_ns);
    int mx, mi;
    exp_set(1, 0, 0, 0);
    noise_in(noise);
    img_valid = 1'b1;
    result_ready = 1'b0;
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    step();
    exp_set(0, 1, 1, 0);
    exp_wdog = 1'b0;
    noise_in(noise);
    img_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    step();
    for (int k = 0; k < run_q.size(); k++) begin
      exp_set(0, 0, 1, 0);
      TU_incre = run_q[k].tu;
      ops = run_q[k].ops;
      done_core_img = (k == run_q.size() - 1) && !wdog_case;
      img_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (run_q[k].tu) begin
        for (int i = 0; i < N; i++)
          if (run_q[k].ops[i] && mcnt[i] < CMAX) mcnt[i]++;
      end
      step();
    end
    mx = 0;
    for (int i = 0; i < N; i++) if (mcnt[i] > mx) mx = mcnt[i];
    mi = 0;
    for (int i = N - 1; i >= 0; i--) if (mcnt[i] == mx) mi = i;
    for (int k = 0; k < N; k++) begin
      exp_set(0, 0, 1, 0);
      if (wdog_case) exp_wdog = 1'b1;
      noise_in(noise);
      img_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    exp_idx = IW'(mi);
    exp_cnt = CW'(mx);
    exp_ns  = (mx == 0);
    exp_set(0, 0, 1, 1);
    if (lit_en) begin
      chk("lit_result_idx", 32'(result_idx), 32'(lit_idx));
      chk("lit_result_cnt", 32'(result_cnt), 32'(lit_cnt));
      chk("lit_no_spike", 32'(no_spike), 32'(lit_ns));
    end
    for (int h = 0; h < hold; h++) begin
      result_ready = 1'b0;
      noise_in(noise);
      img_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    result_ready = 1'b1;
    noise_in(noise);
    img_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    step();
    result_ready = 1'b0;
    img_valid = 1'b0;
    noise_in(noise);
    exp_set(1, 0, 0, 0);
    step();
    run_q.delete();
  endtask

  initial begin
    exp_set(1, 0, 0, 0);
    exp_wdog = 1'b0;
    exp_idx = '0; exp_cnt = '0; exp_ns = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_img_ready", 32'(img_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start_core_img), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_result_idx", 32'(result_idx), 32'd0);
    chk("rst_result_cnt", 32'(result_cnt), 32'd0);
    chk("rst_no_spike", 32'(no_spike), 32'd0);
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      noise_in(1'b1);
      img_valid = 1'b0;
      step();
    end

    // Neuron 2 fires 5 times, neuron 0 three times.
    for (int k = 0; k < 5; k++) begin push(1'b1, 8'h04); push(1'b0, 8'hFF); end
    for (int k = 0; k < 3; k++) push(1'b1, 8'h01);
    push(1'b0, 8'h00);
    do_image(2, 1'b0, 1'b0, 1'b1, 2, 5, 0);

    // Tie between neurons 3 and 6 at four spikes.
    for (int k = 0; k < 4; k++) begin push(1'b1, 8'h40); push(1'b1, 8'h08); end
    push(1'b1, 8'h01); push(1'b1, 8'h01);
    push(1'b0, 8'h00);
    do_image(1, 1'b1, 1'b0, 1'b1, 3, 4, 0);

`ifndef IMG_SEQ_WDOG_EN
    // Saturation: neuron 1 on 300 strobes, neuron 7 on 200.
    for (int k = 0; k < 300; k++) push(1'b1, (k < 200) ? 8'h82 : 8'h02);
    do_image(0, 1'b1, 1'b0, 1'b1, 1, 255, 0);
`endif

    // No spikes sampled: ops only active while TU_incre is low.
    for (int k = 0; k < 20; k++) push(1'b0, N'($urandom));
    for (int k = 0; k < 5; k++) push(1'b1, 8'h00);
    do_image(3, 1'b1, 1'b0, 1'b1, 0, 0, 1);

    // Long hold with noise; final spike coincident with done must count.
    for (int k = 0; k < 3; k++) begin push(1'b1, 8'h80); push(1'b1, 8'h01); end
    push(1'b1, 8'h80);
    do_image(10, 1'b1, 1'b0, 1'b1, 7, 4, 0);

`ifdef IMG_SEQ_WDOG_EN
    for (int k = 0; k < WDOG; k++) push(1'($urandom_range(0, 1)), N'($urandom));
    do_image(2, 1'b0, 1'b1, 1'b0, 0, 0, 0);
`endif

    for (int img = 0; img < 30; img++) begin
      int len;
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++)
        push(1'($urandom_range(0, 3) != 0), N'($urandom & $urandom & $urandom));
      do_image($urandom_range(0, 5), 1'b1, 1'b0, 1'b0, 0, 0, 0);
    end

    // Reset asserted in the middle of RUN with counters nonzero.
    chk_en = 1'b0;
    noise_in(1'b0);
    img_valid = 1'b1;
    step();
    img_valid = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      TU_incre = 1'b1;
      ops = 8'hFF;
      step();
    end
    chk("mid_run_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_img_ready", 32'(img_ready), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;
    noise_in(1'b0);
    chk("post_rst_img_ready", 32'(img_ready), 32'd1);
    chk("post_rst_start", 32'(start_core_img), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_result_valid", 32'(result_valid), 32'd0);
    chk("post_rst_result_idx", 32'(result_idx), 32'd0);
    chk("post_rst_result_cnt", 32'(result_cnt), 32'd0);
    chk("post_rst_no_spike", 32'(no_spike), 32'd0);
    exp_set(1, 0, 0, 0);
    exp_wdog = 1'b0;
    chk_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      noise_in(1'b1);
      img_valid = 1'b0;
      step();
    end
    for (int k = 0; k < 12; k++) push(1'b1, N'($urandom));
    do_image(1, 1'b1, 1'b0, 1'b0, 0, 0, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/img_seq_ctrl.md
IMG_SEQ_CTRL -- requirements
Module: img_seq_ctrl

Interface
REQ-001 Parameter N, default 8: number of output neurons observed on ops.
REQ-002 Parameter CW, default 8: width of each per-neuron spike counter.
REQ-003 Parameter WDOG, default 65535: watchdog limit in clk cycles for the RUN state.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 img_valid  input  1  host has an image presented on the core input path.
REQ-007 img_ready  output  1  controller accepts an image this cycle.
REQ-008 start_core_img  output  1  single-cycle pulse that starts the core for one image.
REQ-009 TU_incre  input  1  core time-unit increment strobe.
REQ-010 ops  input  N  core output spikes, sampled only when TU_incre=1.
REQ-011 done_core_img  input  1  core finished the current image.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 result_valid  output  1  classification result available.
REQ-014 result_ready  input  1  host consumes the result.
REQ-015 result_idx  output  clog2(N)  winning neuron index.
REQ-016 result_cnt  output  CW  winning neuron spike count.
REQ-017 no_spike  output  1  no output neuron fired during the image.

Function
REQ-018 The FSM SHALL have the states IDLE, START, RUN, ARGMAX and RESULT.
REQ-019 In IDLE, img_ready SHALL be 1; img_valid=1 SHALL cause a handshake, clear all N counters, and move to START.
REQ-020 START SHALL last exactly one cycle, assert start_core_img for that cycle only, and then move to RUN.
REQ-021 In RUN, every cycle with TU_incre=1 SHALL increment counter[i] for each ops[i]=1; counters SHALL saturate at 2^CW-1.
REQ-022 done_core_img=1 in RUN SHALL move to ARGMAX; a coincident TU_incre/ops sample in that cycle SHALL still be counted.
REQ-023 done_core_img and TU_incre outside RUN SHALL be ignored.
REQ-024 ARGMAX SHALL scan the counters sequentially over exactly N cycles, index 0 first, keeping the running maximum with a strict greater-than compare, so a tie resolves to the lowest index.
REQ-025 After the scan, ARGMAX SHALL move to RESULT with result_valid=1.
REQ-026 no_spike SHALL be 1 when all counters are 0; in that case result_idx=0 and result_cnt=0.
REQ-027 result_valid, result_idx, result_cnt and no_spike SHALL hold stable until the cycle with result_ready=1, after which the FSM SHALL return to IDLE.
REQ-028 img_ready SHALL be 0 outside IDLE, so a new image is never accepted until the previous result has been consumed.
REQ-029 Start-to-result latency SHALL be (cycles from START to done_core_img) + N + 1 cycles.

Reset
REQ-030 rst=1 SHALL force IDLE immediately, from any state including mid-RUN.
REQ-031 Reset values: img_ready=1, start_core_img=0, busy=0, result_valid=0, result_idx=0, result_cnt=0, no_spike=0, all counters 0, watchdog 0.
REQ-032 The first transition after rst deasserts SHALL require a fresh img_valid.

Configuration
REQ-033 Macro IMG_SEQ_WDOG_EN SHALL compile the RUN watchdog in or out.
REQ-034 With the macro defined:
- A cycle counter SHALL clear on entry to RUN and increment each RUN cycle.
- When it reaches WDOG with done_core_img still 0, the FSM SHALL proceed to ARGMAX.
- It SHALL also set a sticky output wdog_err=1, which is cleared only by rst or by the next img_valid handshake.
REQ-035 Without the macro, neither the watchdog counter nor the wdog_err port SHALL exist, and RUN SHALL wait indefinitely for done_core_img.

Verification
REQ-036 Reset mid-RUN with counters nonzero -> the next cycle shows IDLE, img_ready=1 and all outputs at their reset values.
REQ-037 N=8; image with ops=8'b0000_0100 on 5 TU_incre strobes and 8'b0000_0001 on 3, then done -> result_idx=2, result_cnt=5, no_spike=0, result_valid exactly 9 cycles after done.
REQ-038 Tie: neurons 3 and 6 each fire 4 times -> result_idx=3, result_cnt=4.
REQ-039 CW=8; neuron 1 fires on 300 strobes -> result_cnt=255, result_idx=1; zero spikes on all neurons -> no_spike=1, result_idx=0.
REQ-040 result_ready held 0 for 10 cycles -> outputs stable and img_valid ignored; result_ready=1 -> IDLE next cycle; done_core_img and TU_incre coincident with ops=8'h80 -> that spike is counted.
REQ-041 IMG_SEQ_WDOG_EN defined, WDOG=100, done_core_img never asserted -> ARGMAX entered after 100 RUN cycles, wdog_err=1 until the next handshake.
